// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N:1 WIDTH-bit stream multiplexer with a registered output.
//
// Picks one valid input channel per cycle (round-robin by default, lowest
// index first when FIXED_PRIO=1) and captures its beat into a single output
// register. The register reloads in the same cycle it is drained, so a
// continuously ready sink sees one beat per clock.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   [N]        per-channel beat present
//   in_ready   [N]        per-channel beat accepted (at most one bit set)
//   in_data    [N*WIDTH]  channel i at [i*WIDTH +: WIDTH]
//   out_valid             output register holds a beat
//   out_ready             sink takes the beat this cycle
//   out_data   [WIDTH]    registered beat
//   out_sel    [SELW]     index of the channel that sourced out_data

// Per-channel slice: turns the shared grant/load decision into this
// channel's ready and contributes its data to the AND-OR output mux.
module rr_arb_lane #(
  parameter int WIDTH = 8
) (
  input  logic             grant,
  input  logic             load_en,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic [WIDTH-1:0] data_gated
);
  assign ready      = load_en & grant;
  assign data_gated = data & {WIDTH{grant}};
endmodule

module rr_arb_mux #(
  parameter  int N          = 4,
  parameter  int WIDTH      = 8,
  parameter  int FIXED_PRIO = 0,
  localparam int SELW       = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel
);

  localparam logic [SELW-1:0] LAST = SELW'(N - 1);
  localparam logic [N-1:0]    ONE  = N'(1);

  logic [SELW-1:0]           ptr;
  logic                      load_en;
  logic [N-1:0]              hi_mask;
  logic [N-1:0]              req_hi;
  logic [N-1:0]              grant;
  logic                      any_grant;
  logic [SELW-1:0]           gidx;
  logic [N-1:0][WIDTH-1:0]   lane_data;
  logic [WIDTH-1:0]          sel_data;

  // The register can take a new beat when empty or being drained. Reset
  // suppresses loading so no source sees ready during the reset cycle.
  assign load_en = (!out_valid || out_ready) && !rst;

  // Round-robin as a two-pass priority pick: first look only at channels
  // at or above ptr; if none is valid, wrap and take the lowest valid one.
  // x & (~x + 1) isolates the lowest set bit. With ptr pinned at 0 the
  // upper pass covers everything, which is exactly fixed priority.
  always_comb begin
    hi_mask   = {N{1'b1}} << ptr;
    req_hi    = in_valid & hi_mask;
    grant     = '0;
    if (|req_hi) grant = req_hi & (~req_hi + ONE);
    else         grant = in_valid & (~in_valid + ONE);
    any_grant = |grant;
  end

  // grant is one-hot, so OR-ing matching indices gives the encoded winner.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++)
      if (grant[i]) gidx = gidx | SELW'(i);
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    rr_arb_lane #(.WIDTH(WIDTH)) u_lane (
      .grant      (grant[i]),
      .load_en    (load_en),
      .data       (in_data[i*WIDTH +: WIDTH]),
      .ready      (in_ready[i]),
      .data_gated (lane_data[i])
    );
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) sel_data = sel_data | lane_data[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      // Loading with no grant just drains the register; data/sel keep
      // their stale values since they are meaningless while !out_valid.
      out_valid <= any_grant;
      if (any_grant) begin
        out_data <= sel_data;
        out_sel  <= gidx;
        // Wrap at N explicitly so non-power-of-two N never points past
        // the last channel.
        if (FIXED_PRIO == 0)
          ptr <= (gidx == LAST) ? '0 : gidx + SELW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: one round-robin and one fixed-priority instance,
// N=4, WIDTH=8. The driver pushes the expected {sel,data} for every beat it
// knows will be accepted; per-instance monitors pop and compare whenever the
// output handshake completes. Cycle-level checks (in_ready, stalls, reset)
// are made directly by the driver.
module tb_rr_arb_mux;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;

  logic [3:0]  rr_iv, rr_ir, fp_iv, fp_ir;
  logic [31:0] rr_id, fp_id;
  logic        rr_ov, rr_or, fp_ov, fp_or;
  logic [7:0]  rr_od, fp_od;
  logic [1:0]  rr_os, fp_os;

  beat_t q_rr[$];
  beat_t q_fp[$];

  int n_chk  = 0;
  int n_pass = 0;

  int rr_seq[6] = '{0, 1, 2, 3, 0, 1};

  always #5 clk = ~clk;

  rr_arb_mux #(.N(4), .WIDTH(8), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .in_valid(rr_iv), .in_ready(rr_ir), .in_data(rr_id),
    .out_valid(rr_ov), .out_ready(rr_or), .out_data(rr_od), .out_sel(rr_os)
  );

  rr_arb_mux #(.N(4), .WIDTH(8), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .in_valid(fp_iv), .in_ready(fp_ir), .in_data(fp_id),
    .out_valid(fp_ov), .out_ready(fp_or), .out_data(fp_od), .out_sel(fp_os)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Pulse reset across one rising edge; leaves us just after that edge.
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin : mon_rr
    beat_t b;
    if (!rst && rr_ov && rr_or) begin
      if (q_rr.size() == 0) begin
        n_chk++;
        $display("FAIL rr_unexpected_beat: got sel=%0d data=0x%0h, want none",
                 rr_os, rr_od);
      end else begin
        b = q_rr.pop_front();
        check("rr_out_sel", 32'(rr_os), 32'(b.sel));
        check("rr_out_data", 32'(rr_od), 32'(b.data));
      end
    end
  end

  always @(negedge clk) begin : mon_fp
    beat_t b;
    if (!rst && fp_ov && fp_or) begin
      if (q_fp.size() == 0) begin
        n_chk++;
        $display("FAIL fp_unexpected_beat: got sel=%0d data=0x%0h, want none",
                 fp_os, fp_od);
      end else begin
        b = q_fp.pop_front();
        check("fp_out_sel", 32'(fp_os), 32'(b.sel));
        check("fp_out_data", 32'(fp_od), 32'(b.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    rr_iv = '0; rr_id = '0; rr_or = 1'b1;
    fp_iv = '0; fp_id = '0; fp_or = 1'b1;

    // 1. reset / idle
    repeat (2) begin
      step(); mid();
      check("rst_out_valid", 32'(rr_ov), 0);
      check("rst_out_data",  32'(rr_od), 0);
      check("rst_out_sel",   32'(rr_os), 0);
      check("rst_in_ready",  32'(rr_ir), 0);
    end
    step();
    rst = 1'b0;
    mid();
    check("idle_out_valid", 32'(rr_ov), 0);
    check("idle_in_ready",  32'(rr_ir), 0);
    step();

    // 2. single source on channel 2
    rr_iv = 4'b0100;
    rr_id = 32'h00A5_0000;
    q_rr.push_back('{sel: 2'd2, data: 8'hA5});
    mid();
    check("single_in_ready", 32'(rr_ir), 32'b0100);
    step();
    rr_iv = '0;
    mid();
    check("single_out_valid", 32'(rr_ov), 1);
    check("single_ptr", 32'(u_rr.ptr), 3);
    step();
    mid();
    check("single_drained", 32'(rr_ov), 0);
    step();

    // 3. round-robin fairness, all channels valid
    do_reset();
    rr_id = 32'h1312_1110;
    rr_iv = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      q_rr.push_back('{sel: 2'(rr_seq[k]), data: 8'(8'h10 + rr_seq[k])});
      mid();
      check("rr_in_ready", 32'(rr_ir), 32'(1) << rr_seq[k]);
      if (k > 0) check("rr_out_valid", 32'(rr_ov), 1);
      step();
    end
    rr_iv = '0;
    mid();
    check("rr_last_valid", 32'(rr_ov), 1);
    step();
    mid();
    check("rr_drained", 32'(rr_ov), 0);
    step();

    // 6. reset while a beat is held
    do_reset();
    rr_iv = 4'b1111;
    q_rr.push_back('{sel: 2'd0, data: 8'h10});
    mid(); step();
    q_rr.push_back('{sel: 2'd1, data: 8'h11});
    mid(); step();
    rst = 1'b1;
    void'(q_rr.pop_back());  // held beat {1,0x11} is discarded by reset
    mid();
    check("midrst_in_ready", 32'(rr_ir), 0);
    step();
    rst = 1'b0;
    q_rr.push_back('{sel: 2'd0, data: 8'h10});
    mid();
    check("midrst_out_valid", 32'(rr_ov), 0);
    check("midrst_out_sel",   32'(rr_os), 0);
    check("midrst_ptr",       32'(u_rr.ptr), 0);
    check("midrst_first_grant", 32'(rr_ir), 32'b0001);
    step();
    rr_iv = '0;
    mid(); step();

    // 4. backpressure with {1,0x11} held and ptr=2
    do_reset();
    rr_iv = 4'b1111;
    q_rr.push_back('{sel: 2'd0, data: 8'h10});
    mid(); step();
    q_rr.push_back('{sel: 2'd1, data: 8'h11});
    mid(); step();
    rr_or = 1'b0;
    repeat (3) begin
      mid();
      check("stall_in_ready",  32'(rr_ir), 0);
      check("stall_out_valid", 32'(rr_ov), 1);
      check("stall_out_sel",   32'(rr_os), 1);
      check("stall_out_data",  32'(rr_od), 32'h11);
      check("stall_ptr",       32'(u_rr.ptr), 2);
      step();
    end
    rr_or = 1'b1;
    q_rr.push_back('{sel: 2'd2, data: 8'h12});
    mid();
    check("release_in_ready", 32'(rr_ir), 32'b0100);
    step();
    rr_iv = '0;
    mid();
    check("release_next_data", 32'(rr_od), 32'h12);
    step();

    // 5. fixed priority instance
    fp_id = 32'h2322_2120;
    fp_iv = 4'b1010;
    repeat (4) begin
      q_fp.push_back('{sel: 2'd1, data: 8'h21});
      mid();
      check("fp_in_ready_low", 32'(fp_ir), 32'b0010);
      step();
    end
    fp_iv = 4'b1000;
    q_fp.push_back('{sel: 2'd3, data: 8'h23});
    mid();
    check("fp_in_ready_high", 32'(fp_ir), 32'b1000);
    step();
    fp_iv = '0;
    mid();
    check("fp_ptr", 32'(u_fp.ptr), 0);
    step();
    mid();

    check("rr_queue_empty", 32'(q_rr.size()), 0);
    check("fp_queue_empty", 32'(q_fp.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
Parametrised N:1, WIDTH-bit multiplexer with valid/ready handshake on every channel. It selects the input channel itself through a round-robin arbiter, or through fixed priority when configured. The selected beat is captured into an output register. The block joins several streaming sources onto one sink, and it extends the gate-level 2:1 mux to wide, multi-channel, clocked datapaths.

Parameters:
N, 4, number of input channels; legal range 2..32.
WIDTH, 8, data bits per channel; must be 1 or more.
FIXED_PRIO, 0, arbitration mode. 0 selects round-robin. 1 selects fixed priority, where the lowest index wins.
SELW, $clog2(N), width of out_sel; derived, never overridden.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  N  bit i set means channel i presents a beat.
in_ready  output  N  bit i set means channel i's beat is accepted this cycle.
in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
out_valid  output  1  output register holds a beat.
out_ready  input  1  sink accepts the beat this cycle.
out_data  output  WIDTH  registered data.
out_sel  output  SELW  index of the channel that sourced out_data.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0. rst takes priority over every other event in that cycle.
- Load enable: load_en = !out_valid || out_ready. A registered beat is replaced in the same cycle it is consumed, giving a throughput of 1 beat/clk.
- Grant (combinational), round-robin mode:
  - Scan indices ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - The first index with in_valid set wins.
- Grant, FIXED_PRIO=1: the lowest index with in_valid set wins; ptr is unused and stays 0.
- Grant vector: one-hot or zero. It is zero when in_valid is all zero.
- Ready: in_ready[i] = load_en && grant[i]. At most one bit of in_ready is set in any cycle.
- Handshake on channel g (in_valid[g] && in_ready[g]):
  - Next edge: out_valid=1, out_data=in_data[g], out_sel=g.
  - Round-robin mode: ptr <= (g+1) mod N, wrapping from N-1 to 0.
- No handshake but out_ready && out_valid: next edge out_valid=0. out_data and out_sel keep their old values, which are don't-care.
- Stall: while out_valid && !out_ready, out_data and out_sel stay stable, all in_ready=0, and ptr holds.
- Latency: a beat accepted at edge k appears on the output after edge k. That is 1 cycle, with no combinational path from in_data to out_data.
- Combinational paths:
  - Allowed: in_valid → in_ready and out_ready → in_ready.
  - Sources must not make in_valid depend on in_ready.
  - A source must hold in_valid and in_data stable until accepted. The block does not check this.
- Losing channels: an unselected valid channel is not consumed. It keeps its beat and is guaranteed service within N grants in round-robin mode.
- Simultaneous consume and load: the output is consumed and the next beat is loaded in the same cycle; out_valid stays 1.
- Reset mid-operation: a held beat is discarded (out_valid=0 next cycle), no in_ready is asserted during the rst cycle, and ptr returns to 0.
- N not a power of two: the wrap is at N, not 2^SELW. Indices ≥ N are never produced on out_sel.

Test Plan:
1. Reset / idle: N=4, WIDTH=8. Hold rst for 2 cycles, then all in_valid=0 → out_valid=0, out_data=0x00, out_sel=0, in_ready=4'b0000 every cycle.
2. Single source: in_valid=4'b0100, in_data[2]=0xA5, out_ready=1 → in_ready=4'b0100 that cycle. Next cycle out_valid=1, out_data=0xA5, out_sel=2, and ptr becomes 3.
3. Round-robin fairness:
   - Stimulus: in_valid=4'b1111 held, out_ready=1, channel i data = 0x10+i.
   - Required out_sel sequence from reset: 0,1,2,3,0,1.
   - Required out_data sequence: 0x10,0x11,0x12,0x13,0x10,0x11.
   - out_valid=1 on every cycle after the first.
4. Backpressure:
   - Stimulus: with out_valid=1, out_sel=1, out_data=0x11, drive out_ready=0 for 3 cycles.
   - Required during the stall: outputs hold, in_ready=0, ptr=2 unchanged.
   - On the release cycle: in_ready=4'b0100 and the next beat is 0x12.
5. Fixed priority: FIXED_PRIO=1, in_valid=4'b1010 held, out_ready=1 → out_sel=1 every cycle and channel 3 is never granted. After in_valid changes to 4'b1000, out_sel=3.
6. Reset mid-stream: during scenario 3, assert rst for 1 cycle while out_valid=1 → the next cycle has out_valid=0 and out_sel=0. After release, the first grant is channel 0.
